// File: rtl/sd_dat_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_dat_tx_ctrl
// Function : Single-DAT-line SD block write sequencer. Streams start bit, FIFO
//            data, CRC16 and end bit, then collects the card CRC status token.
//            Define SD_DAT_TX_BUSY_EN to also wait out card busy before done.
// Revision : 1.0
// ============================================================================
module sd_dat_tx_ctrl #(
  parameter int BLOCK_BYTES  = 512,
  parameter int CNT_W        = 13,
  parameter int STAT_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rdreq,
  output logic        crc_clear,
  output logic        crc_shift,
  output logic        crc_bit,
  input  logic [15:0] crc_value,
  output logic        dat_out,
  output logic        dat_oe,
  input  logic        dat_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  status
);

  localparam int WAIT_MAX = (BUSY_TIMEOUT > STAT_TIMEOUT) ? BUSY_TIMEOUT : STAT_TIMEOUT;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int CW       = (CNT_W > WAIT_W) ? CNT_W : WAIT_W;

  localparam logic [CW-1:0] c_last_bit  = CW'(8 * BLOCK_BYTES - 1);
  localparam logic [CW-1:0] c_last_byte = CW'(8 * (BLOCK_BYTES - 1));
  localparam logic [CW-1:0] c_stat_last = CW'(STAT_TIMEOUT - 1);
  localparam logic [2:0]    c_tok_ok    = 3'b010;
  localparam logic [2:0]    c_tok_fail  = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_CRC,
    S_END,
    S_STAT_WAIT,
    S_STAT,
`ifdef SD_DAT_TX_BUSY_EN
    S_BUSY,
`endif
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [15:0]   crc_sh_q, crc_sh_d;
  logic [2:0]    status_q, status_d;
  logic          drive;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      crc_sh_q <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      crc_sh_q <= crc_sh_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    crc_sh_d   = crc_sh_q;
    status_d   = status_q;
    drive      = 1'b0;
    dat_out    = 1'b1;
    crc_clear  = 1'b0;
    crc_shift  = 1'b0;
    crc_bit    = 1'b0;
    fifo_rdreq = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    status     = status_q;

    case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        crc_clear = 1'b1;
        cnt_d     = '0;
        if (start) begin
          if (fifo_empty) begin
            done     = 1'b1;
            error    = 1'b1;
            status   = c_tok_fail;
            status_d = c_tok_fail;
          end else begin
            fifo_rdreq = 1'b1;
            status_d   = '0;
            state_d    = S_START;
          end
        end
      end
      S_START: begin
        drive   = 1'b1;
        dat_out = 1'b0;
        shreg_d = fifo_data;
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        drive     = 1'b1;
        dat_out   = shreg_q[7];
        crc_shift = 1'b1;
        crc_bit   = shreg_q[7];
        shreg_d   = {shreg_q[6:0], 1'b0};
        cnt_d     = cnt_q + CW'(1);
        // Prefetch the next byte one bit early so it lands exactly at bit 7.
        if (cnt_q[2:0] == 3'd6 && cnt_q < c_last_byte) begin
          if (fifo_empty) begin
            status_d = c_tok_fail;
            state_d  = S_FIN;
          end else begin
            fifo_rdreq = 1'b1;
          end
        end
        if (cnt_q[2:0] == 3'd7) begin
          shreg_d = fifo_data;
          if (cnt_q == c_last_bit) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end
        end
      end
      S_CRC: begin
        drive = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == '0) begin
          dat_out  = crc_value[15];
          crc_sh_d = {crc_value[14:0], 1'b0};
        end else begin
          dat_out  = crc_sh_q[15];
          crc_sh_d = {crc_sh_q[14:0], 1'b0};
        end
        if (cnt_q == CW'(15)) begin
          cnt_d   = '0;
          state_d = S_END;
        end
      end
      S_END: begin
        drive   = 1'b1;
        cnt_d   = '0;
        state_d = S_STAT_WAIT;
      end
      S_STAT_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (!dat_in) begin
          cnt_d   = '0;
          state_d = S_STAT;
        end else if (cnt_q == c_stat_last) begin
          status_d = c_tok_fail;
          state_d  = S_FIN;
        end
      end
      S_STAT: begin
        status_d = {status_q[1:0], dat_in};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(2)) begin
          cnt_d = '0;
`ifdef SD_DAT_TX_BUSY_EN
          state_d = S_BUSY;
`else
          state_d = S_FIN;
`endif
        end
      end
`ifdef SD_DAT_TX_BUSY_EN
      // First cycle here is the token end bit, so it never ends the wait.
      S_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q != '0 && dat_in) begin
          state_d = S_FIN;
        end else if (cnt_q == CW'(BUSY_TIMEOUT)) begin
          status_d = c_tok_fail;
          state_d  = S_FIN;
        end
      end
`endif
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        error   = (status_q != c_tok_ok);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The line is released as soon as reset is asserted, not one edge later.
    dat_oe = drive & rst;
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_dat_tx_ctrl.sv
`default_nettype none
// Bench for sd_dat_tx_ctrl: FIFO/card models drive directed blocks, and a
// per-cycle protocol model derived from the block contents checks the outputs.
module tb_sd_dat_tx_ctrl;
  localparam int N = 4;
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst, start, fifo_empty, fifo_rdreq;
  logic [7:0]  fifo_data;
  logic        crc_clear, crc_shift, crc_bit;
  logic [15:0] crc_value;
  logic        dat_out, dat_oe, dat_in;
  logic        busy, done, error;
  logic [2:0]  status;

  always #5 clk = ~clk;

  sd_dat_tx_ctrl #(
    .BLOCK_BYTES (N),
    .CNT_W       (13),
    .STAT_TIMEOUT(T),
    .BUSY_TIMEOUT(65535)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rdreq(fifo_rdreq),
    .crc_clear (crc_clear),
    .crc_shift (crc_shift),
    .crc_bit   (crc_bit),
    .crc_value (crc_value),
    .dat_out   (dat_out),
    .dat_oe    (dat_oe),
    .dat_in    (dat_in),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .status    (status)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  blk[$];
  logic [7:0]  fifo_q[$];
  logic [63:0] cap_line;
  int          cap_len, rd_count, obs_done;
  logic [2:0]  obs_st;
  logic        obs_err;

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic card_bit(input int k, input int tok_at, input logic [2:0] tok, input int busy_len);
    if (tok_at < 0 || k < tok_at) return 1'b1;
    if (k == tok_at) return 1'b0;
    if (k <= tok_at + 3) return tok[2 - (k - tok_at - 1)];
    if (k == tok_at + 4) return 1'b1;
    if (k <= tok_at + 4 + busy_len) return 1'b0;
    return 1'b1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs one block from blk; k=0 is the cycle start is sampled.
  task automatic run_block(input int tok_at, input logic [2:0] tok, input int busy_len,
                           input int extra_start, input int rst_at);
    int m, done_k, line_last, shift_last, n_stop, j;
    logic [2:0] st;
    logic line[$];
    logic rd, post, oe_e, rd_e, sh_e;
    m = blk.size();
    fifo_q = blk;
    line = {};
    line.push_back(1'b0);
    foreach (blk[i]) for (int b = 7; b >= 0; b--) line.push_back(blk[i][b]);
    if (m == N) begin
      for (int b = 15; b >= 0; b--) line.push_back(crc_value[b]);
      line.push_back(1'b1);
    end
    if (m == 0) begin
      done_k = 0; st = 3'b111; line_last = 0;
    end else if (m < N) begin
      done_k = 8 * m + 1; st = 3'b111; line_last = 8 * m;
    end else if (tok_at < 0) begin
      done_k = 8 * N + 19 + T; st = 3'b111; line_last = 8 * N + 18;
    end else begin
      st = tok; line_last = 8 * N + 18;
`ifdef SD_DAT_TX_BUSY_EN
      done_k = tok_at + 6 + busy_len;
`else
      done_k = tok_at + 4;
`endif
    end
    shift_last = (m < N) ? 8 * m : 8 * N + 1;
    n_stop = (rst_at >= 0) ? rst_at + 2 : done_k + 2;
    obs_done = -1; obs_st = 3'b000; obs_err = 1'b0;
    rd_count = 0; cap_line = '0; cap_len = 0;
    fifo_empty = (fifo_q.size() == 0);
    for (int k = 0; k <= n_stop; k++) begin
      start  = (k == 0) || (k == extra_start);
      rst    = (k != rst_at);
      dat_in = card_bit(k, tok_at, tok, busy_len);
      @(negedge clk);
      post = (rst_at >= 0) && (k > rst_at);
      oe_e = !post && k >= 1 && k <= line_last && k != rst_at;
      j    = (k - 8) / 8;
      rd_e = !post && m > 0 &&
             (k == 0 || (k >= 8 && k <= shift_last && (k % 8) == 0 && j < N - 1 && j + 1 < m));
      sh_e = !post && k >= 2 && k <= shift_last;
      chk("dat_oe", k, 64'(dat_oe), 64'(oe_e));
      if (oe_e) chk("dat_out", k, 64'(dat_out), 64'(line[k - 1]));
      if (post) chk("dat_out_idle", k, 64'(dat_out), 64'd1);
      chk("fifo_rdreq", k, 64'(fifo_rdreq), 64'(rd_e));
      chk("rdreq_while_empty", k, 64'(fifo_rdreq & fifo_empty), 64'd0);
      chk("crc_shift", k, 64'(crc_shift), 64'(sh_e));
      if (sh_e) chk("crc_bit", k, 64'(crc_bit), 64'(line[k - 1]));
      if (post || k == 0) chk("crc_clear_idle", k, 64'(crc_clear), 64'd1);
      else if (k <= shift_last) chk("crc_clear_run", k, 64'(crc_clear), 64'd0);
      chk("busy", k, 64'(busy), 64'(!post && k >= 1 && k < done_k));
      chk("done", k, 64'(done), 64'(!post && k == done_k));
      if (!post && k == done_k) begin
        chk("error", k, 64'(error), 64'(st != 3'b010));
        chk("status", k, 64'(status), 64'(st));
      end
      if (dat_oe) begin
        cap_line = {cap_line[62:0], dat_out};
        cap_len++;
      end
      if (fifo_rdreq) rd_count++;
      if (done && obs_done < 0) begin
        obs_done = k; obs_st = status; obs_err = error;
      end
      rd = fifo_rdreq;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
    start = 1'b0; rst = 1'b1; dat_in = 1'b1;
    fifo_q.delete();
    fifo_empty = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [49:0] good_line;
    good_line = 50'b0_10100101_00111100_00000000_11111111_1011111011101111_1;
    crc_value = 16'hBEEF;
    rst = 1'b0; start = 1'b0; dat_in = 1'b1; fifo_empty = 1'b1; fifo_data = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_dat_out", -1, 64'(dat_out), 64'd1);
    chk("rst_crc_clear", -1, 64'(crc_clear), 64'd1);
    chk("rst_dat_oe", -1, 64'(dat_oe), 64'd0);
    chk("rst_busy", -1, 64'(busy), 64'd0);
    chk("rst_done", -1, 64'(done), 64'd0);
    chk("rst_error", -1, 64'(error), 64'd0);
    chk("rst_status", -1, 64'(status), 64'd0);
    chk("rst_rdreq", -1, 64'(fifo_rdreq), 64'd0);
    chk("rst_crc_shift", -1, 64'(crc_shift), 64'd0);
    chk("rst_crc_bit", -1, 64'(crc_bit), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // Good block, with a stray start pulse during DATA
    blk = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
    run_block(8 * N + 21, 3'b010, 0, 20, -1);
    chk("good_line_len", -1, 64'(cap_len), 64'd50);
    chk("good_line_bits", -1, cap_line, 64'(good_line));
    chk("good_rdreq_count", -1, 64'(rd_count), 64'd4);
`ifdef SD_DAT_TX_BUSY_EN
    chk("good_done_cycle", -1, 64'(obs_done), 64'd59);
`else
    chk("good_done_cycle", -1, 64'(obs_done), 64'd57);
`endif
    chk("good_status", -1, 64'(obs_st), 64'd2);
    chk("good_error", -1, 64'(obs_err), 64'd0);
    idle(3);

    // Rejected CRC token
    blk = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_block(8 * N + 25, 3'b101, 0, -1, -1);
    chk("reject_status", -1, 64'(obs_st), 64'd5);
    chk("reject_error", -1, 64'(obs_err), 64'd1);
    idle(3);

    // FIFO underflow after two bytes
    blk = '{8'h5A, 8'hC3};
    run_block(-1, 3'b000, 0, -1, -1);
    chk("under_rdreq_count", -1, 64'(rd_count), 64'd2);
    chk("under_done_cycle", -1, 64'(obs_done), 64'd17);
    chk("under_status", -1, 64'(obs_st), 64'd7);
    chk("under_error", -1, 64'(obs_err), 64'd1);
    idle(3);

    // Status token never arrives
    blk = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_block(-1, 3'b000, 0, -1, -1);
    chk("tmo_done_cycle", -1, 64'(obs_done), 64'd115);
    chk("tmo_status", -1, 64'(obs_st), 64'd7);
    idle(3);

    // Card holds busy for 100 cycles after the token
    blk = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_block(8 * N + 21, 3'b010, 100, -1, -1);
`ifdef SD_DAT_TX_BUSY_EN
    chk("busy_done_cycle", -1, 64'(obs_done), 64'd159);
`else
    chk("busy_done_cycle", -1, 64'(obs_done), 64'd57);
`endif
    idle(3);

    // Start with an empty FIFO
    blk = {};
    run_block(-1, 3'b000, 0, -1, -1);
    chk("empty_done_cycle", -1, 64'(obs_done), 64'd0);
    chk("empty_status", -1, 64'(obs_st), 64'd7);
    chk("empty_error", -1, 64'(obs_err), 64'd1);
    idle(3);

    // Reset at cycle 10 of DATA, then a clean block
    blk = '{8'hA5, 8'h3C, 8'h00, 8'hFF};
    run_block(-1, 3'b000, 0, -1, 11);
    idle(2);
    blk = '{8'h0F, 8'hF0, 8'h81, 8'h7E};
    run_block(8 * N + 22, 3'b010, 0, -1, -1);
    chk("after_rst_line_len", -1, 64'(cap_len), 64'd50);
    chk("after_rst_start_bit", -1, 64'(cap_line[49]), 64'd0);
    chk("after_rst_error", -1, 64'(obs_err), 64'd0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_dat_tx_ctrl.md
# sd_dat_tx_ctrl

Sequencer for a single SD DAT-line block write. It pulls bytes from the write FIFO, serialises start bit, data, CRC16 and end bit onto the line, and drives the external CRC16 engine (clear/shift/bit) while doing so. It then receives the card's CRC status token and, optionally, waits out card busy. It sits between the write FIFO and the SD pad logic, one instance per DAT line.

## Interface
- BLOCK_BYTES, 512, bytes per block (≥2)
- CNT_W, 13, width of the bit counter (must hold 8*BLOCK_BYTES-1)
- STAT_TIMEOUT, 64, max cycles from end bit to status start bit
- BUSY_TIMEOUT, 65535, max busy cycles (used only with the busy feature)

Ports:
- clk  in  1  line-rate clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  pulse; begin one block (ignored unless idle)
- fifo_empty  in  1  write FIFO empty
- fifo_data  in  8  FIFO read data, valid the cycle after fifo_rdreq
- fifo_rdreq  out  1  FIFO read strobe, one cycle per byte
- crc_clear  out  1  hold CRC engine at its initial value
- crc_shift  out  1  CRC engine absorbs crc_bit this edge
- crc_bit  out  1  bit fed to CRC engine (= dat_out during data)
- crc_value  in  16  CRC engine register; reflects shifts up to the previous edge
- dat_out  out  1  DAT line drive value
- dat_oe  out  1  DAT line output enable
- dat_in  in  1  DAT line sampled value
- busy  out  1  block in progress
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; 1 = underflow, timeout or rejected status
- status  out  3  CRC status token bits; 3'b111 on underflow/timeout

## Operation
- States: IDLE, START, DATA, CRC, END, STAT_WAIT, STAT, BUSY (macro only), FIN.
- IDLE: dat_oe=0, dat_out=1, crc_clear=1, busy=0. On start: if fifo_empty, pulse done with error=1, status=3'b111, and stay in IDLE. Otherwise assert fifo_rdreq and go to START.
- START: dat_oe=1, dat_out=0, crc_clear=0. Load shift register from fifo_data. Go to DATA.
- DATA: 8*BLOCK_BYTES cycles, MSB first. dat_out=shreg[7], crc_shift=1, crc_bit=dat_out.
  - Bit 6 of every byte except the last: fifo_rdreq=1. If fifo_empty at that point, abort.
  - Bit 7: reload shreg from fifo_data.
- CRC: on entry, latch crc_value. Shift 16 bits MSB first, crc_shift=0.
- END: dat_out=1 for one cycle.
- STAT_WAIT: dat_oe=0. Wait for dat_in=0 (token start bit). Timeout after STAT_TIMEOUT cycles -> abort.
- STAT: sample 3 dat_in bits into status, MSB first.
- BUSY: wait while dat_in=0. Timeout -> abort.
- FIN: done=1; error=(status!=3'b010); go to IDLE.
- Abort: dat_oe=0, status=3'b111, done=1, error=1, return to IDLE.
- start while not IDLE is ignored.

## Timing
- Reset values: dat_out=1, crc_clear=1; all other outputs 0; state IDLE.
- rst low mid-block: the next edge forces reset values. The line is released the same cycle the reset is sampled.
- Cycle numbering: start sampled at cycle 0, N=BLOCK_BYTES.
  - Start bit on dat_out at cycle 1.
  - Data bits at cycles 2..8N+1.
  - CRC at cycles 8N+2..8N+17.
  - End bit at cycle 8N+18.
  - dat_oe low from cycle 8N+19.
- fifo_rdreq pulses: cycle 0, then once per byte at bit 6, N pulses total. Never asserted while fifo_empty.
- crc_shift is high for exactly 8N cycles per block.
- status sampling: the three token bits are taken on the three cycles after dat_in is first seen low.
- done is high for exactly one cycle and busy drops on the same cycle.

## Configuration
- SD_DAT_TX_BUSY_EN defined: the BUSY state and BUSY_TIMEOUT are present. done is delayed until dat_in returns high.
- SD_DAT_TX_BUSY_EN undefined: STAT goes directly to FIN, busy is never waited on, and BUSY_TIMEOUT is unused.

## Test plan
- Good block (BLOCK_BYTES=4): FIFO holds A5 3C 00 FF, CRC model frozen at 16'hBEEF, card returns token 010 after 2 idle cycles.
  - dat_out must be 0, then 10100101 00111100 00000000 11111111, then 1011111011101111, then 1.
  - Expect done with error=0 and status=3'b010.
- Rejected CRC: card returns token 101 -> done, error=1, status=3'b101.
- Underflow: FIFO holds 2 bytes -> abort at bit 6 of byte 1. Expect fifo_rdreq count 2, dat_oe=0 the next cycle, status=3'b111, error=1.
- Status timeout: dat_in held high -> done after STAT_TIMEOUT cycles in STAT_WAIT, status=3'b111, error=1.
- Busy (macro defined): dat_in low for 100 cycles after the token -> done 1 cycle after dat_in rises.
  - Macro undefined: done follows the token directly.
- Reset at cycle 10 of DATA, then start again -> clean block with a correct start bit and crc_clear high in between. A start pulse issued during DATA is ignored.
